div_arbiter: RTL
================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter NREQ, 4: number of requesters sharing one divider, 2..8.
REQ-002 Parameter W, 32: operand/result width.
REQ-003 Parameter TIMEOUT, 64: max cycles waited for divider completion, >=2.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NREQ  per-requester operation request.
REQ-007 req_ready  out  NREQ  one-hot accept; transfer when req_valid[i]&req_ready[i].
REQ-008 req_a  in  NREQ*W  dividends; slice i = bits [i*W +: W].
REQ-009 req_b  in  NREQ*W  divisors, same slicing.
REQ-010 rsp_valid  out  NREQ  one-hot, one-cycle result strobe to the owning requester.
REQ-011 rsp_d / rsp_r  out  W each  quotient / remainder; valid only with rsp_valid.
REQ-012 rsp_err  out  1  divide error (divisor zero or div_err).
REQ-013 rsp_timeout  out  1  divider did not complete within TIMEOUT.
REQ-014 div_start  out  1  one-cycle start pulse to divider.
REQ-015 div_a / div_b  out  W each  operands, held stable from div_start until completion or timeout.
REQ-016 div_d / div_r  in  W each  divider quotient / remainder.
REQ-017 div_ok / div_err  in  1 each  divider completion / error strobes.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; only one operation in flight.
REQ-020 IDLE: req_ready is one-hot for the round-robin winner (first valid index searching upward from last_grant+1, wrapping), zero when no req_valid.
REQ-021 On acceptance: latch index, operands; go ISSUE, or go RESP with rsp_err=1, d=r=0 if divisor is zero (divider not started).
REQ-022 ISSUE: div_start=1 exactly one cycle, clear wait counter, go WAIT.
REQ-023 WAIT: counter increments each cycle; div_err -> latch err; else div_ok -> latch div_d/div_r; either -> RESP.
REQ-024 div_ok and div_err in the same cycle: err wins, rsp_d=rsp_r=0.
REQ-025 Counter reaching TIMEOUT-1 without completion -> RESP with rsp_timeout=1, d=r=0; completion in that same cycle wins over timeout.
REQ-026 RESP: rsp_valid[index]=1 one cycle, last_grant<=index, go IDLE.
REQ-027 div_ok/div_err outside WAIT ignored.
REQ-028 Latency: accept at cycle N, div_start at N+1, rsp_valid one cycle after completion strobe sampled.
REQ-029 A requester dropping req_valid before acceptance loses no state; no requester is granted twice while another is continuously valid.

Reset
REQ-030 reset_n low: state IDLE, last_grant=NREQ-1 (requester 0 wins first), counter 0.
REQ-031 All outputs 0 during reset, including div_start, div_a, div_b, rsp_*.
REQ-032 Reset mid-operation abandons the operation with no rsp_valid; divider shares the same reset.

Structure
REQ-033 Shared package holds FSM state encoding and default W/NREQ/TIMEOUT constants.
REQ-034 One sub-module rr_arbiter (NREQ-wide round-robin pick from request vector and last_grant).

Verification
REQ-035 Single request, req 0: A=1023, B=50 -> div_start once, rsp_valid=0001, rsp_d=20, rsp_r=23, err=0.
REQ-036 All four valid together, B nonzero -> grants in order 0,1,2,3, then 0; no re-grant starvation.
REQ-037 req 2: A=7, B=0 -> no div_start, rsp_valid=0100, rsp_err=1, d=r=0.
REQ-038 Divider model never completes, TIMEOUT=64 -> rsp_timeout=1 exactly 64 cycles after div_start, FSM returns IDLE.
REQ-039 div_ok and div_err same cycle -> rsp_err=1; stray div_ok in IDLE -> no rsp_valid.
REQ-040 reset_n asserted during WAIT -> outputs 0 asynchronously, no rsp_valid, next request served normally.

Source files
------------

// File: rtl/div_arbiter_pkg.sv
// Shared constants and FSM encoding for the divider-sharing arbiter.
package div_arbiter_pkg;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_W       = 32;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/div_arbiter_if.sv
// Requester and divider handshake bundle; slave is the arbiter side, master the environment side.
interface div_arbiter_if
  import div_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_d;
  logic [W-1:0]      rsp_r;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              div_start;
  logic [W-1:0]      div_a;
  logic [W-1:0]      div_b;
  logic [W-1:0]      div_d;
  logic [W-1:0]      div_r;
  logic              div_ok;
  logic              div_err;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, div_d, div_r, div_ok, div_err,
    output req_ready, rsp_valid, rsp_d, rsp_r, rsp_err, rsp_timeout,
           div_start, div_a, div_b, busy
  );

  modport master (
    output req_valid, req_a, req_b, div_d, div_r, div_ok, div_err,
    input  req_ready, rsp_valid, rsp_d, rsp_r, rsp_err, rsp_timeout,
           div_start, div_a, div_b, busy
  );
endinterface

// File: rtl/div_arbiter_rr_arbiter.sv
// Round-robin pick: first requester searching upward from last_i+1, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o
);
  logic          found_s;
  logic [IW-1:0] cand_s;

  // search order starts just above the previous winner
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IW'((int'(last_i) + k) % NREQ);
      if (!found_s && req_i[cand_s]) begin
        found_s         = 1'b1;
        grant_o[cand_s] = 1'b1;
        idx_o           = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end
endmodule

// File: rtl/div_arbiter.sv
// Shares one external divider among NREQ requesters, one operation in flight,
// with zero-divisor short-circuit and completion timeout.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset_n,
  div_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d, idx_q, idx_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, d_q, d_d, r_q, r_d;
  logic            err_q, err_d, to_q, to_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] grant_s;
  logic [IW-1:0]   win_s;
  logic [W-1:0]    win_a_s, win_b_s;
  logic            in_idle_s, in_resp_s;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req_i   (bus.req_valid),
    .last_i  (last_q),
    .grant_o (grant_s),
    .idx_o   (win_s)
  );

  // AND-OR mux of the winner's operands using the one-hot grant
  always_comb begin
    win_a_s = '0;
    win_b_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_a_s = win_a_s | (bus.req_a[i*W +: W] & {W{grant_s[i]}});
      win_b_s = win_b_s | (bus.req_b[i*W +: W] & {W{grant_s[i]}});
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    r_d     = r_q;
    err_d   = err_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant_s) begin
          idx_d = win_s;
          a_d   = win_a_s;
          b_d   = win_b_s;
          d_d   = '0;
          r_d   = '0;
          to_d  = 1'b0;
          if (win_b_s == '0) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // completion beats a timeout landing in the same cycle
        if (bus.div_err) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (bus.div_ok) begin
          d_d     = bus.div_d;
          r_d     = bus.div_r;
          state_d = ST_RESP;
        end else if (cnt_d == CW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        last_d  = idx_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NREQ - 1);
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      r_q     <= r_d;
      err_q   <= err_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_idle_s       = (state_q == ST_IDLE);
  assign in_resp_s       = (state_q == ST_RESP);
  assign bus.req_ready   = (in_idle_s && reset_n) ? grant_s : '0;
  assign bus.rsp_valid   = in_resp_s ? (NREQ'(1) << idx_q) : '0;
  assign bus.rsp_d       = in_resp_s ? d_q : '0;
  assign bus.rsp_r       = in_resp_s ? r_q : '0;
  assign bus.rsp_err     = in_resp_s & err_q;
  assign bus.rsp_timeout = in_resp_s & to_q;
  assign bus.div_start   = (state_q == ST_ISSUE);
  assign bus.div_a       = a_q;
  assign bus.div_b       = b_q;
  assign bus.busy        = !in_idle_s;
endmodule
